// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and sizing helpers for the burst system controller.
package sys_ctrl_pkg;

    localparam logic [7:0] OP_WR      = 8'hAA;
    localparam logic [7:0] OP_RD      = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;
    localparam logic [7:0] OP_BWR     = 8'hEE;
    localparam logic [7:0] OP_BRD     = 8'hEF;

    typedef enum logic [3:0] {
        StIdle,
        StGetAddr,
        StGetCnt,
        StGetData,
        StGetA,
        StGetB,
        StGetFun,
        StRdWait,
        StRdSend,
        StAluWait,
        StAluSend
    } state_e;

    function automatic int unsigned alu_bytes(input int unsigned out_w, input int unsigned data_w);
        return out_w / data_w;
    endfunction

    localparam int unsigned ALU_BYTES = alu_bytes(16, 8);

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle counter; expire_o pulses once the gap reaches TIMEOUT_CYCLES enabled cycles.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && !clr_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sys_ctrl_burst.sv
// Byte-serial command decoder driving register-file and ALU accesses, with burst transfers,
// multi-byte ALU result return, TX FIFO back-pressure and an inter-byte frame timeout.
module sys_ctrl_burst
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned ALU_OUT_WIDTH  = 16,
    parameter int unsigned ALU_FUN_WIDTH  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic                     WR_EN,
    output logic                     RD_EN,
    output logic [ADDR_WIDTH-1:0]    ADDRESS,
    output logic [DATA_WIDTH-1:0]    WR_DATA,
    input  logic [DATA_WIDTH-1:0]    RD_DATA,
    input  logic                     RD_DATA_VLD,
    output logic                     ALU_EN,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     FIFO_FULL,
    output logic                     BUSY,
    output logic                     FRAME_ERR
);

    localparam int unsigned AluBytes = alu_bytes(ALU_OUT_WIDTH, DATA_WIDTH);
    localparam int unsigned BlW      = $clog2(AluBytes + 1);

    state_e                   state_q, state_d;
    logic [7:0]               op_q, op_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    rd_byte_q, rd_byte_d;
    logic [ALU_OUT_WIDTH-1:0] alu_res_q, alu_res_d;
    logic [BlW-1:0]           bytes_left_q, bytes_left_d;
    logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;
    logic                     gate_q, gate_d;
    logic                     alu_go_q, alu_go_d;
    logic                     wr_en_q, wr_en_d;
    logic                     rd_en_q, rd_en_d;
    logic                     alu_en_q, alu_en_d;
    logic                     err_q, err_d;
    logic                     tx_vld;
    logic [DATA_WIDTH-1:0]    tx_data;
    logic [7:0]               rx_op;
    logic                     in_get, timer_clr, timeout;

    assign in_get    = state_q inside {StGetAddr, StGetCnt, StGetData, StGetA, StGetB, StGetFun};
    assign timer_clr = RX_D_VLD || !in_get;
    assign rx_op     = 8'(RX_P_DATA);

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (timer_clr),
        .en_i    (in_get),
        .expire_o(timeout)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rd_byte_d    = rd_byte_q;
        alu_res_d    = alu_res_q;
        bytes_left_d = bytes_left_q;
        alu_fun_d    = alu_fun_q;
        gate_d       = gate_q;
        alu_go_d     = alu_go_q;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        alu_en_d     = 1'b0;
        err_d        = 1'b0;
        tx_vld       = 1'b0;
        tx_data      = rd_byte_q;

        // Burst-write address advances in the cycle its WR_EN pulse is on the bus.
        if (wr_en_q && op_q == OP_BWR) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (RX_D_VLD) begin
                    op_d = rx_op;
                    case (rx_op)
                        OP_WR, OP_RD, OP_BWR, OP_BRD: state_d = StGetAddr;
                        OP_ALU_OP:                    state_d = StGetA;
                        OP_ALU_NOP:                   state_d = StGetFun;
                        default:                      err_d   = 1'b1;
                    endcase
                end
            end
            StGetAddr: begin
                if (RX_D_VLD) begin
                    addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    if (op_q == OP_WR) begin
                        state_d = StGetData;
                    end else if (op_q == OP_RD) begin
                        rd_en_d = 1'b1;
                        state_d = StRdWait;
                    end else begin
                        state_d = StGetCnt;
                    end
                end
            end
            StGetCnt: begin
                if (RX_D_VLD) begin
                    cnt_d = RX_P_DATA;
                    if (RX_P_DATA == '0) begin
                        state_d = StIdle;
                    end else if (op_q == OP_BWR) begin
                        state_d = StGetData;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = StRdWait;
                    end
                end
            end
            StGetData: begin
                if (RX_D_VLD) begin
                    wdata_d = RX_P_DATA;
                    wr_en_d = 1'b1;
                    cnt_d   = cnt_q - DATA_WIDTH'(1);
                    if (op_q == OP_WR || cnt_q == DATA_WIDTH'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            StGetA: begin
                if (RX_D_VLD) begin
                    addr_d  = '0;
                    wdata_d = RX_P_DATA;
                    wr_en_d = 1'b1;
                    state_d = StGetB;
                end
            end
            StGetB: begin
                if (RX_D_VLD) begin
                    addr_d  = ADDR_WIDTH'(1);
                    wdata_d = RX_P_DATA;
                    wr_en_d = 1'b1;
                    state_d = StGetFun;
                end
            end
            StGetFun: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    gate_d    = 1'b1;
                    alu_go_d  = 1'b1;
                    state_d   = StAluWait;
                end
            end
            StRdWait: begin
                err_d = RX_D_VLD;
                if (RD_DATA_VLD) begin
                    rd_byte_d = RD_DATA;
                    state_d   = StRdSend;
                end
            end
            StRdSend: begin
                err_d = RX_D_VLD;
                if (!FIFO_FULL) begin
                    tx_vld = 1'b1;
                    if (op_q == OP_BRD && cnt_q != DATA_WIDTH'(1)) begin
                        cnt_d   = cnt_q - DATA_WIDTH'(1);
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        rd_en_d = 1'b1;
                        state_d = StRdWait;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StAluWait: begin
                err_d = RX_D_VLD;
                // Gate opens one cycle ahead of the enable so the ALU clock is running.
                if (alu_go_q) begin
                    alu_en_d = 1'b1;
                    alu_go_d = 1'b0;
                end else if (ALU_OUT_VLD) begin
                    alu_res_d    = ALU_OUT;
                    gate_d       = 1'b0;
                    bytes_left_d = BlW'(AluBytes);
                    state_d      = StAluSend;
                end
            end
            StAluSend: begin
                err_d   = RX_D_VLD;
                tx_data = alu_res_q[DATA_WIDTH-1:0];
                if (!FIFO_FULL) begin
                    tx_vld       = 1'b1;
                    alu_res_d    = alu_res_q >> DATA_WIDTH;
                    bytes_left_d = bytes_left_q - BlW'(1);
                    if (bytes_left_q == BlW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (timeout) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rd_byte_q    <= '0;
            alu_res_q    <= '0;
            bytes_left_q <= '0;
            alu_fun_q    <= '0;
            gate_q       <= 1'b0;
            alu_go_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            alu_en_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rd_byte_q    <= rd_byte_d;
            alu_res_q    <= alu_res_d;
            bytes_left_q <= bytes_left_d;
            alu_fun_q    <= alu_fun_d;
            gate_q       <= gate_d;
            alu_go_q     <= alu_go_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            alu_en_q     <= alu_en_d;
            err_q        <= err_d;
        end
    end

    assign WR_EN       = wr_en_q;
    assign RD_EN       = rd_en_q;
    assign ADDRESS     = addr_q;
    assign WR_DATA     = wdata_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = gate_q;
    assign TX_P_DATA   = tx_data;
    assign TX_D_VLD    = tx_vld;
    assign BUSY        = (state_q != StIdle);
    assign FRAME_ERR   = err_q;

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed bench for sys_ctrl_burst with simple register-file and ALU responders.
module tb_sys_ctrl_burst;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        WR_EN, RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD, BUSY, FRAME_ERR;
    logic [3:0]  ADDRESS, ALU_FUN;
    logic [7:0]  WR_DATA, TX_P_DATA;
    logic [7:0]  RD_DATA = 8'h00;
    logic        RD_DATA_VLD = 1'b0;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD = 1'b0;
    logic        FIFO_FULL;

    int checks = 0;
    int failures = 0;

    logic [3:0] wr_a[$];
    logic [7:0] wr_d[$];
    logic [7:0] tx_q[$];
    int         ferr_cnt, rden_cnt, aluen_cnt, viol_cnt;
    logic [3:0] fun_last;
    logic       rd_pend = 1'b0;
    logic [3:0] rd_addr = 4'h0;
    logic       alu_pend = 1'b0;

    sys_ctrl_burst #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (4),
        .ALU_OUT_WIDTH (16),
        .ALU_FUN_WIDTH (4),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .WR_EN      (WR_EN),
        .RD_EN      (RD_EN),
        .ADDRESS    (ADDRESS),
        .WR_DATA    (WR_DATA),
        .RD_DATA    (RD_DATA),
        .RD_DATA_VLD(RD_DATA_VLD),
        .ALU_EN     (ALU_EN),
        .ALU_FUN    (ALU_FUN),
        .ALU_OUT    (ALU_OUT),
        .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .FIFO_FULL  (FIFO_FULL),
        .BUSY       (BUSY),
        .FRAME_ERR  (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    // Register file returns 0xA0+addr one cycle after RD_EN; ALU answers one cycle after ALU_EN.
    always @(posedge CLK) begin
        #1;
        RD_DATA_VLD = rd_pend;
        RD_DATA     = 8'hA0 + {4'h0, rd_addr};
        rd_pend     = RD_EN;
        rd_addr     = ADDRESS;
        ALU_OUT_VLD = alu_pend;
        alu_pend    = ALU_EN;
    end

    always @(negedge CLK) begin
        if (WR_EN) begin
            wr_a.push_back(ADDRESS);
            wr_d.push_back(WR_DATA);
        end
        if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
        if (TX_D_VLD && FIFO_FULL) viol_cnt++;
        if (FRAME_ERR) ferr_cnt++;
        if (RD_EN) rden_cnt++;
        if (ALU_EN) begin
            aluen_cnt++;
            fun_last = ALU_FUN;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick(1);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic clr_logs();
        wr_a.delete();
        wr_d.delete();
        tx_q.delete();
        ferr_cnt  = 0;
        rden_cnt  = 0;
        aluen_cnt = 0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 80 && BUSY; i++) tick(1);
        check(tag, {31'd0, BUSY}, 32'd0);
        tick(2);
    endtask

    initial begin
        RST = 1'b1; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; FIFO_FULL = 1'b0; ALU_OUT = 16'h0000;
        viol_cnt = 0; fun_last = 4'h0;
        clr_logs();
        tick(3);
        RST = 1'b0;
        tick(1);
        check("rst_outs", {WR_EN, RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD, BUSY, FRAME_ERR}, 32'd0);
        check("rst_addr_data", {ADDRESS, WR_DATA, ALU_FUN, TX_P_DATA}, 32'd0);

        // Single write
        send(8'hAA); send(8'h05); send(8'h3C);
        check("wr_en", {31'd0, WR_EN}, 32'd1);
        check("wr_addr", {28'd0, ADDRESS}, 32'h5);
        check("wr_data", {24'd0, WR_DATA}, 32'h3C);
        check("wr_busy", {31'd0, BUSY}, 32'd0);
        tick(1);
        check("wr_en_pulse", {31'd0, WR_EN}, 32'd0);
        tick(1);
        check("wr_count", wr_a.size(), 32'd1);

        // Burst write with address wrap, bytes back to back
        clr_logs();
        send(8'hEE); send(8'h0E); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        wait_idle("bw_idle");
        check("bw_count", wr_a.size(), 32'd3);
        check("bw_0", {wr_a[0], wr_d[0]}, 32'h0E11);
        check("bw_1", {wr_a[1], wr_d[1]}, 32'h0F22);
        check("bw_2", {wr_a[2], wr_d[2]}, 32'h0033);
        check("bw_ferr", ferr_cnt, 32'd0);

        // Burst with N=0
        clr_logs();
        send(8'hEE); send(8'h03); send(8'h00);
        check("bw0_busy", {31'd0, BUSY}, 32'd0);
        tick(2);
        check("bw0_none", wr_a.size() + ferr_cnt, 32'd0);

        // Burst read with back-pressure on the first byte
        clr_logs();
        FIFO_FULL = 1'b1;
        send(8'hEF); send(8'h02); send(8'h02);
        tick(6);
        check("br_held", tx_q.size(), 32'd0);
        check("br_held_busy", {31'd0, BUSY}, 32'd1);
        FIFO_FULL = 1'b0;
        #1;
        check("br_release", {23'd0, TX_D_VLD, TX_P_DATA}, 32'h1A2);
        tick(1);
        wait_idle("br_idle");
        check("br_count", tx_q.size(), 32'd2);
        check("br_bytes", {tx_q[0], tx_q[1]}, 32'hA2A3);
        check("br_rden", rden_cnt, 32'd2);

        // ALU with operands
        clr_logs();
        ALU_OUT = 16'h000A;
        send(8'hCC); send(8'h07); send(8'h03); send(8'h00);
        check("alu_gate_rise", {30'd0, CLK_GATE_EN, ALU_EN}, 32'h2);
        tick(1);
        check("alu_en", {31'd0, ALU_EN}, 32'd1);
        wait_idle("alu_idle");
        check("alu_wr", {wr_a[0], wr_d[0], wr_a[1], wr_d[1]}, 32'h0071_03 | 32'h0);
        check("alu_tx", {tx_q.size(), tx_q[0], tx_q[1]} & 32'hFFFFFF, 32'h020A00);
        check("alu_gate_fall", {31'd0, CLK_GATE_EN}, 32'd0);
        check("alu_en_cnt", aluen_cnt, 32'd1);

        // ALU without operands, stray byte during the wait
        clr_logs();
        ALU_OUT = 16'h1234;
        send(8'hDD); send(8'h05); send(8'h77);
        check("nop_err_en", {30'd0, FRAME_ERR, ALU_EN}, 32'h3);
        wait_idle("nop_idle");
        check("nop_fun", {28'd0, fun_last}, 32'h5);
        check("nop_tx", {tx_q[0], tx_q[1]}, 32'h3412);
        check("nop_wr_none", wr_a.size(), 32'd0);

        // Timeout in the data phase
        clr_logs();
        send(8'hAA); send(8'h05);
        tick(20);
        check("to_wait", {30'd0, BUSY, FRAME_ERR}, 32'h2);
        tick(1);
        check("to_abort", {30'd0, BUSY, FRAME_ERR}, 32'h1);
        tick(2);
        check("to_no_wr", wr_a.size(), 32'd0);

        // Unknown opcode, then reset mid burst read
        clr_logs();
        send(8'h55);
        check("bad_op", {30'd0, BUSY, FRAME_ERR}, 32'h1);
        send(8'hEF); send(8'h03); send(8'h04);
        tick(2);
        check("rst_mid_busy", {31'd0, BUSY}, 32'd1);
        RST = 1'b1;
        #1;
        check("rst_async", {BUSY, RD_EN, TX_D_VLD, FRAME_ERR, ADDRESS}, 32'd0);
        tick(2);
        RST = 1'b0;
        tick(1);
        send(8'hAA); send(8'h09); send(8'h5A);
        check("post_rst_wr", {WR_EN, ADDRESS, WR_DATA}, {19'd0, 1'b1, 4'h9, 8'h5A});

        check("fifo_viol", viol_cnt, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
